// File: rtl/s_32bit_2_unfold.sv
// Folded two-beat receiver: rebuilds a pair of 2*HALF_W-bit words from a HI beat
// followed by an XOR-folded low beat, with a registered, back-pressurable output stage.
module s_32bit_2_unfold #(
    parameter int          HALF_W  = 16,
    parameter logic [15:0] CNT_RST = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [HALF_W-1:0]     in_aa,
    input  logic [HALF_W-1:0]     in_bb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*HALF_W-1:0]   out_a,
    output logic [2*HALF_W-1:0]   out_b,
    output logic [15:0]           word_cnt,
    output logic                  sync_err
);

    typedef enum logic [0:0] {
        S_HI   = 1'b0,
        S_FOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [HALF_W-1:0]    r_hi_a;
    logic [HALF_W-1:0]    r_hi_b;
    logic [2*HALF_W-1:0]  r_out_a;
    logic [2*HALF_W-1:0]  r_out_b;
    logic                 r_out_valid;
    logic [15:0]          r_word_cnt;
    logic                 r_sync_err;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_load_hi;
    logic                 w_load_out;
    logic                 w_set_err;

    assign w_accept = in_valid && w_in_ready;

    // Next-state, input handshake and register load enables
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b1;
        w_load_hi   = 1'b0;
        w_load_out  = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            S_HI: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    if (in_sof) begin
                        w_load_hi   = 1'b1;
                        w_state_nxt = S_FOLD;
                    end else begin
                        w_set_err   = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_HI;
                end
            end
            S_FOLD: begin
                // A FOLD beat needs a free (or draining) output slot
                w_in_ready = !r_out_valid || out_ready;
                if (w_accept) begin
                    if (!in_sof) begin
                        w_load_out  = 1'b1;
                        w_state_nxt = S_HI;
                    end else begin
                        w_load_hi   = 1'b1;
                        w_set_err   = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_FOLD;
                end
            end
            default: begin
                w_state_nxt = S_HI;
                w_in_ready  = 1'b1;
            end
        endcase
    end

    // State, held HI half, output pair, counter and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_HI;
            r_hi_a      <= {HALF_W{1'b0}};
            r_hi_b      <= {HALF_W{1'b0}};
            r_out_a     <= {(2*HALF_W){1'b0}};
            r_out_b     <= {(2*HALF_W){1'b0}};
            r_out_valid <= 1'b0;
            r_word_cnt  <= CNT_RST;
            r_sync_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_hi) begin
                r_hi_a <= in_aa;
                r_hi_b <= in_bb;
            end
            if (w_load_out) begin
                r_out_a     <= {r_hi_a, in_aa ^ r_hi_a};
                r_out_b     <= {r_hi_b, in_bb ^ r_hi_b};
                r_out_valid <= 1'b1;
                r_word_cnt  <= r_word_cnt + 16'd1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_set_err) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign word_cnt  = r_word_cnt;
    assign sync_err  = r_sync_err;

endmodule
